// File: rtl/neogeo_pkg.sv
// Shared types, default lock parameters and the 5-bit to 8-bit colour expansion
// for the Neo Geo video output stage.
package neogeo_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam int LOCK_FRAMES_DEF   = 8;
    localparam int UNLOCK_MISSES_DEF = 3;
    localparam int FRAME_TOL_DEF     = 16;
    localparam int TIMEOUT_VCLKS_DEF = 2000000;

    // DARK lowers the colour by one half-step below the 5-bit code; top bits repeat
    // into the LSBs so full scale reaches 255.
    function automatic logic [7:0] expand5to8(input logic [4:0] c, input logic dark);
        logic [5:0] v;
        v = {c, ~dark};
        return {v, v[5:4]};
    endfunction

endpackage

// File: rtl/neogeo_lock_fsm.sv
// Frame-lock tracker: frame-start edge detect, period compare against the previous
// frame, match/miss counters and a no-frame watchdog.
import neogeo_pkg::*;

module neogeo_lock_fsm #(
    parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF,
    parameter int UNLOCK_MISSES = UNLOCK_MISSES_DEF,
    parameter int FRAME_TOL     = FRAME_TOL_DEF,
    parameter int TIMEOUT_VCLKS = TIMEOUT_VCLKS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_change,
    input  logic [21:0] vclks_per_frame,
    output logic [1:0]  lock_state,
    output logic        locked
);

    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam int SW = $clog2(UNLOCK_MISSES + 1);
    localparam int TW = $clog2(TIMEOUT_VCLKS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_VCLKS - 1);

    lock_state_t   state, state_nx;
    logic [MW-1:0] match_ctr, match_nx;
    logic [SW-1:0] miss_ctr, miss_nx;
    logic [TW-1:0] to_ctr, to_nx;
    logic [21:0]   ref_cnt;
    logic [21:0]   diff;
    logic          fc_prev;
    logic          fe;
    logic          match;
    logic          timeout;

    assign fe      = frame_change & ~fc_prev;
    assign diff    = (vclks_per_frame >= ref_cnt) ? (vclks_per_frame - ref_cnt)
                                                  : (ref_cnt - vclks_per_frame);
    assign match   = fe & (diff <= 22'(FRAME_TOL));
    assign timeout = (to_ctr == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNLOCKED;
            match_ctr <= '0;
            miss_ctr  <= '0;
            to_ctr    <= '0;
            ref_cnt   <= '0;
            fc_prev   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nx;
            match_ctr <= match_nx;
            miss_ctr  <= miss_nx;
            to_ctr    <= to_nx;
            fc_prev   <= frame_change;
            locked    <= (state == LOCKED);
            if (fe) ref_cnt <= vclks_per_frame;
        end
    end

    always_comb begin
        state_nx = state;
        match_nx = match_ctr;
        miss_nx  = miss_ctr;
        if (fe)
            to_nx = '0;
        else if (to_ctr != TO_LAST)
            to_nx = to_ctr + TW'(1);
        else
            to_nx = to_ctr;

        // Watchdog has priority over a coincident frame event.
        if (timeout) begin
            state_nx = UNLOCKED;
            match_nx = '0;
            miss_nx  = '0;
            to_nx    = '0;
        end else if (fe) begin
            case (state)
                UNLOCKED: begin
                    state_nx = ACQUIRE;
                    match_nx = '0;
                    miss_nx  = '0;
                end
                ACQUIRE: begin
                    if (!match) begin
                        match_nx = '0;
                    end else if (match_ctr == MW'(LOCK_FRAMES - 1)) begin
                        state_nx = LOCKED;
                        match_nx = '0;
                        miss_nx  = '0;
                    end else begin
                        match_nx = match_ctr + MW'(1);
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_nx = '0;
                    end else if (miss_ctr == SW'(UNLOCK_MISSES - 1)) begin
                        state_nx = UNLOCKED;
                        miss_nx  = '0;
                        match_nx = '0;
                    end else begin
                        miss_nx = miss_ctr + SW'(1);
                    end
                end
                default: state_nx = UNLOCKED;
            endcase
        end
    end

    assign lock_state = state;

endmodule

// File: rtl/neogeo_video_out.sv
// Neo Geo video output stage: 2-cycle RGB555+DARK to RGB888 pipeline plus frame lock.
// Define NEO_UNLOCK_BLANK_EN to blank RGB/DE while not locked.
import neogeo_pkg::*;

module neogeo_video_out #(
    parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF,
    parameter int UNLOCK_MISSES = UNLOCK_MISSES_DEF,
    parameter int FRAME_TOL     = FRAME_TOL_DEF,
    parameter int TIMEOUT_VCLKS = TIMEOUT_VCLKS_DEF
) (
    input  logic        VCLK_i,
    input  logic        RESET_i,
    input  logic [4:0]  R_i,
    input  logic [4:0]  G_i,
    input  logic [4:0]  B_i,
    input  logic        DARK_i,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    input  logic        DE_i,
    input  logic        frame_change_i,
    input  logic [21:0] vclks_per_frame_i,
    output logic [7:0]  R_o,
    output logic [7:0]  G_o,
    output logic [7:0]  B_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic        DE_o,
    output logic        locked_o,
    output logic [1:0]  lock_state_o
);

    logic [7:0] s1_r, s1_g, s1_b;
    logic       s1_de, s1_hs, s1_vs;
    logic       blank;

    neogeo_lock_fsm #(
        .LOCK_FRAMES  (LOCK_FRAMES),
        .UNLOCK_MISSES(UNLOCK_MISSES),
        .FRAME_TOL    (FRAME_TOL),
        .TIMEOUT_VCLKS(TIMEOUT_VCLKS)
    ) u_lock (
        .clk            (VCLK_i),
        .rst            (RESET_i),
        .frame_change   (frame_change_i),
        .vclks_per_frame(vclks_per_frame_i),
        .lock_state     (lock_state_o),
        .locked         (locked_o)
    );

`ifdef NEO_UNLOCK_BLANK_EN
    assign blank = ~locked_o;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge VCLK_i) begin
        if (RESET_i) begin
            s1_r  <= '0;
            s1_g  <= '0;
            s1_b  <= '0;
            s1_de <= 1'b0;
            s1_hs <= 1'b1;
            s1_vs <= 1'b1;
        end else begin
            s1_r  <= expand5to8(R_i, DARK_i);
            s1_g  <= expand5to8(G_i, DARK_i);
            s1_b  <= expand5to8(B_i, DARK_i);
            s1_de <= DE_i;
            s1_hs <= HSYNC_i;
            s1_vs <= VSYNC_i;
        end
    end

    // Syncs are never blanked so the downstream scaler keeps its timing.
    always_ff @(posedge VCLK_i) begin
        if (RESET_i) begin
            R_o     <= '0;
            G_o     <= '0;
            B_o     <= '0;
            DE_o    <= 1'b0;
            HSYNC_o <= 1'b1;
            VSYNC_o <= 1'b1;
        end else begin
            R_o     <= blank ? 8'd0 : s1_r;
            G_o     <= blank ? 8'd0 : s1_g;
            B_o     <= blank ? 8'd0 : s1_b;
            DE_o    <= s1_de & ~blank;
            HSYNC_o <= s1_hs;
            VSYNC_o <= s1_vs;
        end
    end

endmodule
